// File: rtl/completion_buffer.sv
// Completion buffer: four per-source result FIFOs, round-robin drained two per cycle
// into registered broadcast slots. Optional CMP_STATS_EN adds broadcast/stall counters.
module completion_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [3:0]           src_valid,
  input  logic [127:0]         src_pc,
  input  logic [4*TAG_W-1:0]   src_tag,
  input  logic [127:0]         src_data,
  output logic [3:0]           src_ready,
  output logic [1:0]           cmp_valid,
  output logic [63:0]          cmp_pc,
  output logic [2*TAG_W-1:0]   cmp_tag,
  output logic [63:0]          cmp_data,
  output logic                 overflow
`ifdef CMP_STATS_EN
  ,
  output logic [31:0]          stat_bcast,
  output logic [31:0]          stat_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [31:0]      pc_mem   [4][DEPTH];
  logic [TAG_W-1:0] tag_mem  [4][DEPTH];
  logic [31:0]      data_mem [4][DEPTH];
  logic [AW:0]      wr_ptr [4];
  logic [AW:0]      rd_ptr [4];

  logic [3:0]       full, empty, push, pop;
  logic [31:0]      head_pc   [4];
  logic [TAG_W-1:0] head_tag  [4];
  logic [31:0]      head_data [4];

  logic [1:0] rr_ptr, rr_next, idx;
  logic [1:0] g_vld;
  logic [1:0] g_src0, g_src1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i]     = (wr_ptr[i] == rd_ptr[i]);
      full[i]      = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                     (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      head_pc[i]   = pc_mem[i][rd_ptr[i][AW-1:0]];
      head_tag[i]  = tag_mem[i][rd_ptr[i][AW-1:0]];
      head_data[i] = data_mem[i][rd_ptr[i][AW-1:0]];
    end
  end

  // Ready comes from registered occupancy only, so a same-cycle pop never raises it.
  assign src_ready = ~full;
  assign push      = src_valid & ~full;

  always_comb begin
    g_vld  = '0;
    g_src0 = '0;
    g_src1 = '0;
    pop    = '0;
    idx    = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!empty[idx]) begin
        if (!g_vld[0]) begin
          g_vld[0] = 1'b1;
          g_src0   = idx;
          pop[idx] = 1'b1;
        end else if (!g_vld[1]) begin
          g_vld[1] = 1'b1;
          g_src1   = idx;
          pop[idx] = 1'b1;
        end
      end
    end
    if (g_vld[1])      rr_next = g_src1 + 2'd1;
    else if (g_vld[0]) rr_next = g_src0 + 2'd1;
    else               rr_next = rr_ptr;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        pc_mem[i][wr_ptr[i][AW-1:0]]   <= src_pc[32*i +: 32];
        tag_mem[i][wr_ptr[i][AW-1:0]]  <= src_tag[TAG_W*i +: TAG_W];
        data_mem[i][wr_ptr[i][AW-1:0]] <= src_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      rr_ptr    <= '0;
      cmp_valid <= '0;
      cmp_pc    <= '0;
      cmp_tag   <= '0;
      cmp_data  <= '0;
      overflow  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
      end
      rr_ptr    <= rr_next;
      cmp_valid <= g_vld;
      // Ungranted slots keep their payload; only the valid bit drops.
      if (g_vld[0]) begin
        cmp_pc[31:0]        <= head_pc[g_src0];
        cmp_tag[TAG_W-1:0]  <= head_tag[g_src0];
        cmp_data[31:0]      <= head_data[g_src0];
      end
      if (g_vld[1]) begin
        cmp_pc[63:32]           <= head_pc[g_src1];
        cmp_tag[2*TAG_W-1:TAG_W] <= head_tag[g_src1];
        cmp_data[63:32]         <= head_data[g_src1];
      end
      if (|(src_valid & ~src_ready)) overflow <= 1'b1;
    end
  end

`ifdef CMP_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_bcast <= '0;
      stat_stall <= '0;
    end else begin
      stat_bcast <= stat_bcast + 32'(g_vld[0]) + 32'(g_vld[1]);
      if (|full) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule
